// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one-line fetch buffer, line-granular I-cache request FSM, instruction queue.
// Optional saturating perf counters are built only when FETCH_PERF_COUNTERS_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'haaaaa000,
  parameter int          LINE_BITS = 256,
  parameter int          DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            icache_addr,
  output logic [3:0]             icache_rmask,
  input  logic [LINE_BITS-1:0]   icache_rdata,
  input  logic                   icache_resp,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [31:0]            deq_instr,
  output logic [31:0]            deq_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            perf_hits,
  output logic [31:0]            perf_misses
);
  localparam int OFF   = $clog2(LINE_BITS/8);
  localparam int WORDS = LINE_BITS/32;
  localparam int TW    = 32 - OFF;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e                     state_q;
  logic                       discard_q;
  logic [31:0]                pc_q;
  logic [31:0]                req_addr_q;
  logic                       lb_valid_q;
  logic [TW-1:0]              lb_tag_q;
  logic [WORDS-1:0][31:0]     lb_words_q;
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [31:0]                q_instr [DEPTH];
  logic [31:0]                q_pc    [DEPTH];

  logic        hit, full, empty, enq, deq, req_start;
  logic [31:0] redir_pc_d;
  logic [31:0] cur_word;
  logic        unused_redir_lsbs;

  assign redir_pc_d        = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsbs = ^redirect_pc[1:0];

  assign hit      = lb_valid_q && (lb_tag_q == pc_q[31:OFF]);
  assign cur_word = lb_words_q[pc_q[OFF-1:2]];
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign enq      = (state_q == S_IDLE) && !redirect_valid && hit && !full;
  assign deq      = !empty && deq_ready;
  assign req_start = (state_q == S_IDLE) && !redirect_valid && !hit;

  // Request address is latched on REQ entry so it stays stable even if a redirect moves pc mid-flight.
  assign icache_addr  = req_addr_q;
  assign icache_rmask = (state_q == S_REQ || state_q == S_WAIT) ? 4'hf : 4'h0;

  assign deq_valid = !empty;
  assign deq_instr = empty ? 32'h0 : q_instr[rptr_q[AW-1:0]];
  assign deq_pc    = empty ? 32'h0 : q_pc[rptr_q[AW-1:0]];
  assign occupancy = wptr_q - rptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      discard_q  <= 1'b0;
      pc_q       <= RESET_PC;
      req_addr_q <= {RESET_PC[31:OFF], {OFF{1'b0}}};
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_words_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q   <= redir_pc_d;
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (enq) begin
          pc_q   <= pc_q + 32'd4;
          wptr_q <= wptr_q + 1'b1;
        end
        if (deq) rptr_q <= rptr_q + 1'b1;
      end
      case (state_q)
        S_IDLE: if (req_start) begin
          state_q    <= S_REQ;
          req_addr_q <= {pc_q[31:OFF], {OFF{1'b0}}};
        end
        S_REQ: state_q <= redirect_valid ? S_IDLE : S_WAIT;
        S_WAIT: begin
          // The outstanding request cannot be cancelled; a redirect only marks its data as stale.
          if (icache_resp) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            if (!discard_q) begin
              lb_valid_q <= 1'b1;
              lb_tag_q   <= req_addr_q[31:OFF];
              lb_words_q <= icache_rdata;
            end
          end else if (redirect_valid) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_instr[wptr_q[AW-1:0]] <= cur_word;
      q_pc[wptr_q[AW-1:0]]    <= pc_q;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] hits_q, misses_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (enq && hits_q != 32'hffffffff)         hits_q   <= hits_q + 32'd1;
      if (req_start && misses_q != 32'hffffffff) misses_q <= misses_q + 32'd1;
    end
  end
  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`else
  assign perf_hits   = 32'h0;
  assign perf_misses = 32'h0;
`endif
endmodule
